// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        B_PRIO = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Byte offset actually used for lane steering; halves and words are
    // forced onto their natural boundary so a misaligned request that slips
    // through unflagged still lands on sane lanes.
    function automatic logic [1:0] lane_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering: store mask/data on the
//               request side, lane select and sign/zero extension on loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_we,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [15:0] w_ld_shift;

    always_comb begin
        o_st_we    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_we    = 4'b0001 << i_st_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_st_we    = 4'b0011 << i_st_lo;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_ld_shift = 16'(i_ld_raw >> {i_ld_lo, 3'b000});

    always_comb begin
        o_ld_data = i_ld_raw;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_ld_shift[7]}},  w_ld_shift[7:0]};
            SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_ld_shift[15]}}, w_ld_shift};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter/sequencer for a single-port data BRAM with
//               starvation protection for port B. Define
//               DMEM_MISALIGN_CHECK_EN to flag misaligned accesses as errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [1:0]               a_size,
    input  logic                     a_unsigned,
    input  logic [31:0]              a_addr,
    input  logic [31:0]              a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [31:0]              a_rdata,
    output logic                     a_err,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [1:0]               b_size,
    input  logic                     b_unsigned,
    input  logic [31:0]              b_addr,
    input  logic [31:0]              b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [31:0]              b_rdata,
    output logic                     b_err,
    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    arb_state_e        r_state, w_state_nxt;
    logic [3:0]        r_wait_cnt, w_wait_nxt;
    logic              w_a_gnt, w_b_gnt, w_gnt, w_err;
    req_t              w_sel;
    logic [1:0]        w_lo;
    logic [3:0]        w_st_we;
    logic [31:0]       w_st_wdata, w_ld_data, w_rd;

    logic              r_a_rvalid, r_b_rvalid, r_err, r_we, r_unsigned;
    logic [1:0]        r_size, r_lo;
    logic [AW-1:0]     r_mem_addr;
    logic [31:0]       r_mem_wdata;

    always_comb begin
        w_a_gnt     = 1'b0;
        w_b_gnt     = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        if (!reset) begin
            case (r_state)
                NORMAL: begin
                    w_a_gnt = a_req;
                    w_b_gnt = b_req & ~a_req;
                    if (!b_req || w_b_gnt)
                        w_wait_nxt = 4'd0;
                    else if (r_wait_cnt < 4'(MAX_WAIT))
                        w_wait_nxt = r_wait_cnt + 4'd1;
                    if (w_wait_nxt >= 4'(MAX_WAIT))
                        w_state_nxt = B_PRIO;
                end
                B_PRIO: begin
                    // Whether B takes its slot or withdrew, the debt is settled.
                    w_b_gnt     = b_req;
                    w_a_gnt     = a_req & ~b_req;
                    w_wait_nxt  = 4'd0;
                    w_state_nxt = NORMAL;
                end
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    assign w_gnt = w_a_gnt | w_b_gnt;
    assign w_sel = w_b_gnt ? '{b_we, b_size, b_unsigned, b_addr, b_wdata}
                           : '{a_we, a_size, a_unsigned, a_addr, a_wdata};
    assign w_lo  = lane_lo(w_sel.size, w_sel.addr[1:0]);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((w_sel.size == SZ_HALF) && w_sel.addr[0]) ||
                        ((w_sel.size == SZ_WORD || w_sel.size == 2'b11) && (w_sel.addr[1:0] != 2'b00));
    assign w_err = (w_sel.addr[31:2] >= 30'(DEPTH)) | w_misalign;
`else
    assign w_err = (w_sel.addr[31:2] >= 30'(DEPTH));
`endif

    dmem_lane_align u_align (
        .i_st_size     (w_sel.size),
        .i_st_lo       (w_lo),
        .i_st_wdata    (w_sel.wdata),
        .o_st_we       (w_st_we),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_lo       (r_lo),
        .i_ld_unsigned (r_unsigned),
        .i_ld_raw      (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    assign mem_en    = w_gnt & ~w_err;
    assign mem_we    = (mem_en && w_sel.we) ? w_st_we : 4'b0000;
    assign mem_addr  = w_gnt ? w_sel.addr[AW+1:2] : r_mem_addr;
    assign mem_wdata = w_gnt ? w_st_wdata : r_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= NORMAL;
            r_wait_cnt  <= 4'd0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= 2'b00;
            r_lo        <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_a_rvalid <= w_a_gnt;
            r_b_rvalid <= w_b_gnt;
            if (w_gnt) begin
                r_err       <= w_err;
                r_we        <= w_sel.we;
                r_unsigned  <= w_sel.is_unsigned;
                r_size      <= w_sel.size;
                r_lo        <= w_lo;
                r_mem_addr  <= mem_addr;
                r_mem_wdata <= mem_wdata;
            end
        end
    end

    // Response outputs are masked by reset so an in-flight access never surfaces.
    assign w_rd     = (r_err || r_we) ? 32'd0 : w_ld_data;
    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid & ~reset;
    assign b_rvalid = r_b_rvalid & ~reset;
    assign a_err    = a_rvalid & r_err;
    assign b_err    = b_rvalid & r_err;
    assign a_rdata  = a_rvalid ? w_rd : 32'd0;
    assign b_rdata  = b_rvalid ? w_rd : 32'd0;

endmodule

`default_nettype wire
